// File: rtl/cu_seq.sv
// Microcode sequencer for the 8-bit CPU core: fetches an opcode over the memory
// path, then walks 1..STEPS external microwords with ALU/memory handshakes.
module cu_seq #(
    parameter int                PC_W       = 16,
    parameter int                IR_W       = 8,
    parameter int                FLAG_W     = 22,
    parameter int                STEPS      = 2,
    parameter logic [FLAG_W-1:0] FETCH_WORD = 22'h100200,
    parameter int                PCC_BIT    = 20,
    parameter logic [FLAG_W-1:0] MEM_MASK   = 22'h102600,
    parameter logic [FLAG_W-1:0] ALU_MASK   = 22'h00001E,
    parameter int                EOI_BIT    = 21,
    parameter int                TIMEOUT    = 0,
    localparam int               STEP_W     = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   halt,
    input  logic [IR_W-1:0]        ir_in,
    output logic [IR_W+STEP_W-1:0] uaddr,
    input  logic [FLAG_W-1:0]      uword,
    input  logic                   mem_done,
    output logic                   mem_exec,
    input  logic                   alu_done,
    output logic                   alu_exec,
    input  logic                   pc_load,
    input  logic [PC_W-1:0]        pc_in,
    output logic [PC_W-1:0]        pc,
    output logic [FLAG_W-1:0]      flags_noc,
    output logic [FLAG_W-1:0]      flags,
    output logic                   highbits_we,
    output logic [STEP_W-1:0]      step,
    output logic                   err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_STEP,
        S_ALU,
        S_MEM,
        S_EVT
    } state_t;

    localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS - 1);

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [IR_W-1:0]    ir_q, ir_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               mem_done_q, alu_done_q;

    logic [FLAG_W-1:0]  w;
    logic               w_alu, w_mem, last;
    logic               mem_rise, alu_rise;
    logic               wait_st, wait_rise, wd_fire, wait_go;

    // Handshake edge detection and watchdog.
    always_comb begin
        mem_rise  = mem_done & ~mem_done_q;
        alu_rise  = alu_done & ~alu_done_q;
        wait_st   = (state_q == S_FETCH) || (state_q == S_ALU) || (state_q == S_MEM);
        wait_rise = (state_q == S_ALU) ? alu_rise : mem_rise;
        wd_fire   = 1'b0;
        if (TIMEOUT > 0) begin
            wd_fire = wait_st && !wait_rise && (cnt_q == CNT_LAST);
        end
        wait_go   = wait_rise || wd_fire;
    end

    // Current flag word and its decoded request classes.
    always_comb begin
        if ((state_q == S_FETCH) || (state_q == S_DECODE)) begin
            w = FETCH_WORD;
        end else begin
            w = uword;
        end
        w_alu = |(w & ALU_MASK);
        w_mem = |(w & MEM_MASK);
        last  = w[EOI_BIT] || (step_q == STEP_LAST);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        step_d  = step_q;
        err_d   = err_q | wd_fire;
        unique case (state_q)
            S_FETCH: begin
                if (wait_go) state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = ir_in;
                step_d  = '0;
                state_d = S_STEP;
            end
            S_STEP: begin
                if (w[PCC_BIT]) pc_d = pc_q + PC_W'(1);
                if (w_alu) begin
                    state_d = S_ALU;
                end else if (w_mem) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_EVT;
                end
            end
            S_ALU: begin
                if (wait_go) state_d = w_mem ? S_MEM : S_EVT;
            end
            S_MEM: begin
                if (wait_go) state_d = S_EVT;
            end
            S_EVT: begin
                if (last) begin
                    pc_d    = pc_load ? pc_in : pc_q + PC_W'(1);
                    state_d = S_FETCH;
                end else begin
                    step_d  = step_q + STEP_W'(1);
                    state_d = S_STEP;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Counter restarts on every state change, so each wait state gets a fresh budget.
        if (TIMEOUT == 0) begin
            cnt_d = '0;
        end else if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_st) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            step_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            mem_done_q <= 1'b1;
            alu_done_q <= 1'b1;
        end else if (!halt) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            mem_done_q <= mem_done;
            alu_done_q <= alu_done;
        end
    end

    // Requests follow done_q so they drop as soon as the slave pulls done low.
    always_comb begin
        mem_exec    = ((state_q == S_FETCH) || (state_q == S_MEM)) ? mem_done_q : 1'b0;
        alu_exec    = (state_q == S_ALU) ? alu_done_q : 1'b0;
        flags_noc   = w;
        if ((state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EVT)) begin
            flags = w;
        end else begin
            flags = '0;
        end
        highbits_we = (state_q == S_EVT) && !last && (step_q == '0);
        uaddr       = {ir_q, step_q};
        pc          = pc_q;
        step        = step_q;
        err         = err_q;
    end

endmodule

// File: tb/tb_cu_seq.sv
// Randomised instruction-level bench for cu_seq with memory/ALU slave emulation
// and an instruction-granular reference model.
module tb_cu_seq;

    localparam int               PC_W       = 16;
    localparam int               IR_W       = 8;
    localparam int               FLAG_W     = 22;
    localparam int               STEPS      = 2;
    localparam int               STEP_W     = 1;
    localparam int               UA_W       = IR_W + STEP_W;
    localparam int               TIMEOUT    = 4;
    localparam int               PCC_BIT    = 20;
    localparam int               EOI_BIT    = 21;
    localparam logic [FLAG_W-1:0] FETCH_WORD = 22'h100200;
    localparam logic [FLAG_W-1:0] MEM_MASK   = 22'h102600;
    localparam logic [FLAG_W-1:0] ALU_MASK   = 22'h00001E;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              halt     = 1'b0;
    logic [IR_W-1:0]   ir_in    = '0;
    logic [UA_W-1:0]   uaddr;
    logic [FLAG_W-1:0] uword;
    logic              mem_done = 1'b1;
    logic              mem_exec;
    logic              alu_done = 1'b1;
    logic              alu_exec;
    logic              pc_load  = 1'b0;
    logic [PC_W-1:0]   pc_in    = '0;
    logic [PC_W-1:0]   pc;
    logic [FLAG_W-1:0] flags_noc;
    logic [FLAG_W-1:0] flags;
    logic              highbits_we;
    logic [STEP_W-1:0] step;
    logic              err;

    logic [FLAG_W-1:0] rom [0:(1<<UA_W)-1];
    assign uword = rom[uaddr];

    int n_assert = 0;
    int n_fail   = 0;
    int m_cnt    = -1;
    int a_cnt    = -1;
    logic [PC_W-1:0] pc_m = '0;
    logic            err_m = 1'b0;

    cu_seq #(
        .PC_W(PC_W), .IR_W(IR_W), .FLAG_W(FLAG_W), .STEPS(STEPS),
        .FETCH_WORD(FETCH_WORD), .PCC_BIT(PCC_BIT), .MEM_MASK(MEM_MASK),
        .ALU_MASK(ALU_MASK), .EOI_BIT(EOI_BIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .ir_in(ir_in), .uaddr(uaddr),
        .uword(uword), .mem_done(mem_done), .mem_exec(mem_exec),
        .alu_done(alu_done), .alu_exec(alu_exec), .pc_load(pc_load),
        .pc_in(pc_in), .pc(pc), .flags_noc(flags_noc), .flags(flags),
        .highbits_we(highbits_we), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 normal, 1 halt 5 cycles in ALU wait, 2 reset mid-MEM, 3 mem_done stuck in MEM
    task automatic run_instr(input logic [IR_W-1:0] op, input logic [FLAG_W-1:0] w0,
                             input logic [FLAG_W-1:0] w1, input logic pl,
                             input logic [PC_W-1:0] pin, input int mode);
        logic [FLAG_W-1:0] ws [STEPS];
        logic [PC_W-1:0]   pc_exp, s_pc;
        logic [UA_W-1:0]   s_ua;
        logic [FLAG_W-1:0] s_fl;
        logic [STEP_W-1:0] s_step;
        int n, pcc, n_alu, n_mem, n_nz;
        int alu_req, mem_req, hb_cnt, nz_cnt, bad_flags, bad_ir, seen, hold_bad;
        int budget, to_k;
        bit in_steps, done, halted;

        ws[0] = w0;
        ws[1] = w1;
        for (int s = 0; s < STEPS; s++) rom[{op, STEP_W'(s)}] = ws[s];

        n = STEPS;
        for (int s = 0; s < STEPS; s++)
            if (n == STEPS && ws[s][EOI_BIT]) n = s + 1;
        pcc = 0; n_alu = 0; n_mem = 1; n_nz = 0;
        for (int s = 0; s < n; s++) begin
            if (ws[s][PCC_BIT]) pcc++;
            if ((ws[s] & ALU_MASK) != 0) n_alu++;
            if ((ws[s] & MEM_MASK) != 0) n_mem++;
            if (ws[s] != 0) n_nz++;
        end
        pc_exp = pl ? pin : pc_m + PC_W'(pcc) + PC_W'(1);

        ir_in = op; pc_load = pl; pc_in = pin;
        alu_req = 0; mem_req = 0; hb_cnt = 0; nz_cnt = 0; bad_flags = 0; bad_ir = 0;
        seen = 0; budget = 0; to_k = -1; in_steps = 0; done = 0; halted = 0;

        while (!done && budget < 300) begin
            if (flags_noc != FETCH_WORD) in_steps = 1;
            else if (in_steps) done = 1;
            if (!done) begin
                if (in_steps) begin
                    if (uaddr[UA_W-1:STEP_W] !== op) bad_ir++;
                    seen |= 1 << uaddr[STEP_W-1:0];
                    if (flags !== '0 && flags !== flags_noc) bad_flags++;
                    if (flags != '0) nz_cnt++;
                end else if (flags !== FETCH_WORD) begin
                    bad_flags++;
                end
                if (highbits_we) hb_cnt++;

                if (to_k >= 0) begin
                    to_k++;
                    if (err) begin
                        check("wd_wait_cycles", 32'(to_k), 32'd4);
                        mem_done = 1'b1; m_cnt = -1; to_k = -1;
                    end
                end

                if (m_cnt == -1 && mem_exec && mem_done) begin
                    mem_req++;
                    if (mode == 2 && in_steps) begin
                        rst_n = 1'b0; mem_done = 1'b0; alu_done = 1'b1;
                        @(negedge clk);
                        check("rst_pc", 32'(pc), 32'd0);
                        check("rst_step", 32'(step), 32'd0);
                        check("rst_uaddr", 32'(uaddr), 32'd0);
                        check("rst_err", 32'(err), 32'd0);
                        check("rst_flags", 32'(flags), 32'(FETCH_WORD));
                        check("rst_mem_exec", 32'(mem_exec), 32'd1);
                        check("rst_alu_exec", 32'(alu_exec), 32'd0);
                        mem_done = 1'b1;
                        @(negedge clk);
                        rst_n = 1'b1;
                        pc_m = '0; err_m = 1'b0; m_cnt = -1; a_cnt = -1;
                        return;
                    end
                    mem_done = 1'b0;
                    if (mode == 3 && in_steps) begin
                        m_cnt = -2; to_k = 0;
                    end else begin
                        m_cnt = $urandom_range(0, 2);
                    end
                end else if (m_cnt == 0) begin
                    mem_done = 1'b1; m_cnt = -1;
                end else if (m_cnt > 0) begin
                    m_cnt--;
                end

                if (a_cnt == -1 && alu_exec && alu_done) begin
                    alu_req++;
                    alu_done = 1'b0;
                    a_cnt = $urandom_range(0, 2);
                    if (mode == 1 && !halted) begin
                        halted = 1; hold_bad = 0;
                        s_pc = pc; s_ua = uaddr; s_fl = flags_noc; s_step = step;
                        halt = 1'b1;
                        repeat (5) begin
                            @(negedge clk);
                            if (pc !== s_pc) hold_bad++;
                            if (uaddr !== s_ua) hold_bad++;
                            if (step !== s_step) hold_bad++;
                            if (flags_noc !== s_fl) hold_bad++;
                            if (alu_exec !== 1'b1) hold_bad++;
                        end
                        halt = 1'b0;
                        check("halt_hold", 32'(hold_bad), 32'd0);
                    end
                end else if (a_cnt == 0) begin
                    alu_done = 1'b1; a_cnt = -1;
                end else if (a_cnt > 0) begin
                    a_cnt--;
                end

                budget++;
                @(negedge clk);
            end
        end
        if (m_cnt == -2) begin
            mem_done = 1'b1; m_cnt = -1;
        end

        pc_m = pc_exp;
        if (mode == 3) err_m = 1'b1;
        check("instr_ended", 32'(done), 32'd1);
        check("pc", 32'(pc), 32'(pc_m));
        check("alu_requests", 32'(alu_req), 32'(n_alu));
        check("mem_requests", 32'(mem_req), 32'(n_mem));
        check("highbits_pulses", 32'(hb_cnt), (n > 1) ? 32'd1 : 32'd0);
        check("steps_visited", 32'(seen), 32'((1 << n) - 1));
        check("flags_gating", 32'(bad_flags), 32'd0);
        check("flags_evt_cycles", 32'(nz_cnt), 32'(n_nz));
        check("uaddr_ir", 32'(bad_ir), 32'd0);
        check("err", 32'(err), 32'(err_m));
    endtask

    task automatic run_random(input int count);
        logic [FLAG_W-1:0] a, b;
        for (int i = 0; i < count; i++) begin
            a = FLAG_W'($urandom) | FLAG_W'(1);
            b = FLAG_W'($urandom) | FLAG_W'(1);
            run_instr(IR_W'($urandom), a, b, 1'($urandom_range(0, 1)), PC_W'($urandom), 0);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << UA_W); i++) rom[i] = '0;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pc", 32'(pc), 32'd0);
        check("reset_step", 32'(step), 32'd0);
        check("reset_uaddr", 32'(uaddr), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_flags", 32'(flags), 32'(FETCH_WORD));
        check("reset_flags_noc", 32'(flags_noc), 32'(FETCH_WORD));
        check("reset_mem_exec", 32'(mem_exec), 32'd1);
        check("reset_alu_exec", 32'(alu_exec), 32'd0);
        check("reset_highbits", 32'(highbits_we), 32'd0);
        rst_n = 1'b1;

        run_instr(8'h3C, 22'h000000, 22'h000000, 1'b0, 16'h0000, 0);
        run_instr(8'h5A, 22'h300000, 22'h000001, 1'b0, 16'h0000, 0);
        run_instr(8'hA5, 22'h000402, 22'h002004, 1'b0, 16'h0000, 0);
        run_instr(8'h11, 22'h200001, 22'h000000, 1'b1, 16'hFFFF, 0);
        run_instr(8'h12, 22'h200001, 22'h000000, 1'b0, 16'h0000, 0);
        run_instr(8'h13, 22'h200001, 22'h000000, 1'b1, 16'h1234, 0);
        run_instr(8'h77, 22'h20000A, 22'h000000, 1'b0, 16'h0000, 1);

        run_random(40);

        run_instr(8'h66, 22'h200400, 22'h000000, 1'b0, 16'h0000, 3);
        run_random(5);

        run_instr(8'h44, 22'h000400, 22'h200001, 1'b0, 16'h0000, 2);
        run_random(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
